// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM state
// encoding and parity-type constants.
package fifo_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_parity.sv
// Parity generator: XOR-reduction of the data word, inverted for odd parity.
module uart_tx_parity_calc
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  typ,
    output logic                  parity
);

    // Even parity is the plain XOR of all bits; odd parity flips it.
    always_comb parity = (^data) ^ (typ == PAR_ODD);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a FIFO read port and serializes
// them as start / data (LSB first) / optional parity / stop, one bit per
// baud tick. Back-to-back frames are fetched directly from STOP.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_BAUD_TICK,
    input  logic                  i_RD_EMPTY,
    input  logic [DATA_WIDTH-1:0] i_RD_DATA,
    output logic                  o_RD_INC,
    input  logic                  i_PAR_EN,
    input  logic                  i_PAR_TYP,
    output logic                  o_TX,
    output logic                  o_BUSY
);

    localparam int              CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] data_q, data_next;
    logic                  par_en_q, par_en_next;
    logic                  par_typ_q, par_typ_next;
    logic [CW-1:0]         cnt_q, cnt_next;
    logic                  tx_q, tx_next;
    logic                  busy_q, busy_next;
    logic                  parity_bit;
    logic                  fetch;

    uart_tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data   (data_q),
        .typ    (par_typ_q),
        .parity (parity_bit)
    );

    // Next-state, latch enables and the registered line value derived from
    // the state being entered, so o_TX changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        data_next    = data_q;
        par_en_next  = par_en_q;
        par_typ_next = par_typ_q;
        cnt_next     = cnt_q;
        tx_next      = tx_q;

        fetch = i_BAUD_TICK && !i_RD_EMPTY && !i_RST &&
                ((state == ST_IDLE) || (state == ST_STOP));

        if (i_BAUD_TICK) begin
            case (state)
                ST_IDLE:   if (fetch) state_next = ST_START;
                ST_START: begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                end
                ST_DATA: begin
                    if (cnt_q == LAST_BIT)
                        state_next = par_en_q ? ST_PARITY : ST_STOP;
                    else
                        cnt_next = cnt_q + 1'b1;
                end
                ST_PARITY: state_next = ST_STOP;
                ST_STOP:   state_next = fetch ? ST_START : ST_IDLE;
                default:   state_next = ST_IDLE;
            endcase
        end

        if (fetch) begin
            data_next    = i_RD_DATA;
            par_en_next  = i_PAR_EN;
            par_typ_next = i_PAR_TYP;
        end

        case (state_next)
            ST_IDLE:   tx_next = 1'b1;
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = data_q[cnt_next];
            ST_PARITY: tx_next = parity_bit;
            ST_STOP:   tx_next = 1'b1;
            default:   tx_next = 1'b1;
        endcase

        busy_next = (state_next != ST_IDLE);
        o_RD_INC  = fetch;
    end

    // State, latches and registered outputs with synchronous reset.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            cnt_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_next;
            data_q    <= data_next;
            par_en_q  <= par_en_next;
            par_typ_q <= par_typ_next;
            cnt_q     <= cnt_next;
            tx_q      <= tx_next;
            busy_q    <= busy_next;
        end
    end

    assign o_TX   = tx_q;
    assign o_BUSY = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a small FIFO model
// and a baud tick every 4 clock cycles.
module tb_fifo_uart_tx;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       tick    = 1'b0;
    logic       par_en  = 1'b0;
    logic       par_typ = 1'b0;
    logic       rd_empty;
    logic       rd_inc;
    logic [7:0] rd_data;
    logic       tx;
    logic       busy;

    logic [7:0] mem [16];
    logic [4:0] rd_ptr = '0;
    logic [4:0] wr_ptr = '0;
    int         inc_count = 0;
    int         phase     = 0;
    int         checks    = 0;
    int         errors    = 0;

    always #5 clk = ~clk;

    assign rd_empty = (rd_ptr == wr_ptr);
    assign rd_data  = rd_empty ? 8'hFF : mem[rd_ptr[3:0]];

    // FIFO read side: pop one word per increment strobe.
    always @(posedge clk) begin
        if (rd_inc) begin
            rd_ptr    <= rd_ptr + 5'd1;
            inc_count <= inc_count + 1;
        end
    end

    // Baud tick: high for one cycle out of every four.
    initial begin
        forever begin
            @(negedge clk);
            tick  = (phase == 3);
            phase = (phase + 1) % 4;
        end
    end

    fifo_uart_tx #(
        .DATA_WIDTH (8)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_BAUD_TICK (tick),
        .i_RD_EMPTY  (rd_empty),
        .i_RD_DATA   (rd_data),
        .o_RD_INC    (rd_inc),
        .i_PAR_EN    (par_en),
        .i_PAR_TYP   (par_typ),
        .o_TX        (tx),
        .o_BUSY      (busy)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[3:0]] = d;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic wait_fall(input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s start bit: tx=%b, required 0 within 100 cycles", name, tx);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(busy === 1'b0 && tx === 1'b1) && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (!(busy === 1'b0 && tx === 1'b1)) begin
            errors++;
            $display("FAIL %s idle: busy=%b tx=%b, required busy=0 tx=1", name, busy, tx);
        end
    endtask

    // Samples n line bits, one per tick interval, starting at the start bit;
    // optionally flips PAR_TYP at bit flip_at. busy_ok drops if o_BUSY is
    // ever low while sampling.
    task automatic capture(input int n, input int flip_at,
                           output logic [31:0] bits, output logic busy_ok);
        bits    = '0;
        busy_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            bits[i] = tx;
            if (i == flip_at) par_typ = ~par_typ;
            for (int k = 0; k < 4; k++) begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                step();
            end
        end
    endtask

    task automatic test_reset();
        logic bad_tx = 1'b0, bad_busy = 1'b0, bad_inc = 1'b0;
        rst    = 1'b1;
        par_en = 1'b0;
        push(8'hA5);
        for (int i = 0; i < 12; i++) begin
            step();
            if (tx !== 1'b1)     bad_tx   = 1'b1;
            if (busy !== 1'b0)   bad_busy = 1'b1;
            if (rd_inc !== 1'b0) bad_inc  = 1'b1;
        end
        checks++; if (bad_tx)   begin errors++; $display("FAIL reset tx: got non-1, required 1"); end
        checks++; if (bad_busy) begin errors++; $display("FAIL reset busy: got non-0, required 0"); end
        checks++; if (bad_inc)  begin errors++; $display("FAIL reset rd_inc: got 1, required 0"); end
        checks++;
        if (inc_count !== 0) begin
            errors++;
            $display("FAIL reset consumed: got %0d reads, required 0", inc_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] bits;
        logic        bok;
        wait_fall("basic");
        capture(10, -1, bits, bok);
        checks++;
        if (bits[9:0] !== 10'b1101001010) begin
            errors++;
            $display("FAIL basic frame: got %b, required %b", bits[9:0], 10'b1101001010);
        end
        checks++; if (!bok) begin errors++; $display("FAIL basic busy: got 0 in frame, required 1"); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic length: busy=%b after 10 bits, required 0", busy); end
        wait_idle("basic");
        checks++;
        if (inc_count !== 1) begin errors++; $display("FAIL basic rd_inc: got %0d pulses, required 1", inc_count); end
    endtask

    task automatic test_parity();
        logic [31:0] bits;
        logic        bok;
        par_en  = 1'b1;
        par_typ = 1'b0;
        push(8'hA5);
        wait_fall("par_even");
        capture(11, -1, bits, bok);
        checks++;
        if (bits[10:0] !== 11'b10101001010) begin
            errors++;
            $display("FAIL par_even frame: got %b, required %b", bits[10:0], 11'b10101001010);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL par_even length: busy=%b after 11 bits, required 0", busy); end
        wait_idle("par_even");
        par_typ = 1'b1;
        push(8'hA5);
        wait_fall("par_odd");
        capture(11, -1, bits, bok);
        checks++;
        if (bits[10:0] !== 11'b11101001010) begin
            errors++;
            $display("FAIL par_odd frame: got %b, required %b", bits[10:0], 11'b11101001010);
        end
        wait_idle("par_odd");
        par_en  = 1'b0;
        par_typ = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        logic        bok;
        int          c0 = inc_count;
        push(8'h01);
        push(8'h80);
        push(8'hFF);
        wait_fall("b2b");
        capture(30, -1, bits, bok);
        checks++;
        if (bits[9:0] !== 10'b1000000010) begin
            errors++; $display("FAIL b2b frame0: got %b, required %b", bits[9:0], 10'b1000000010);
        end
        checks++;
        if (bits[19:10] !== 10'b1100000000) begin
            errors++; $display("FAIL b2b frame1: got %b, required %b", bits[19:10], 10'b1100000000);
        end
        checks++;
        if (bits[29:20] !== 10'b1111111110) begin
            errors++; $display("FAIL b2b frame2: got %b, required %b", bits[29:20], 10'b1111111110);
        end
        checks++; if (!bok) begin errors++; $display("FAIL b2b busy: got 0 between frames, required 1"); end
        wait_idle("b2b");
        checks++;
        if (inc_count !== c0 + 3) begin
            errors++; $display("FAIL b2b rd_inc: got %0d pulses, required 3", inc_count - c0);
        end
    endtask

    task automatic test_par_toggle();
        logic [31:0] bits;
        logic        bok;
        par_en  = 1'b1;
        par_typ = 1'b0;
        push(8'hA5);
        wait_fall("par_toggle");
        capture(11, 3, bits, bok);
        checks++;
        if (bits[10:0] !== 11'b10101001010) begin
            errors++;
            $display("FAIL par_toggle frame: got %b, required %b", bits[10:0], 11'b10101001010);
        end
        wait_idle("par_toggle");
        par_en  = 1'b0;
        par_typ = 1'b0;
    endtask

    task automatic test_empty();
        logic bad_tx = 1'b0, bad_busy = 1'b0, bad_inc = 1'b0;
        int   c0 = inc_count;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1)     bad_tx   = 1'b1;
            if (busy !== 1'b0)   bad_busy = 1'b1;
            if (rd_inc !== 1'b0) bad_inc  = 1'b1;
        end
        checks++; if (bad_tx)   begin errors++; $display("FAIL empty tx: got non-1, required 1"); end
        checks++; if (bad_busy) begin errors++; $display("FAIL empty busy: got non-0, required 0"); end
        checks++;
        if (bad_inc || inc_count !== c0) begin
            errors++; $display("FAIL empty rd_inc: got %0d pulses, required 0", inc_count - c0);
        end
    endtask

    task automatic test_fetch_timing();
        logic bad = 1'b0;
        int   c0  = inc_count;
        int   n   = 0;
        while (tick !== 1'b1 && n < 8) begin step(); n++; end
        step();
        push(8'h0F);
        n = 0;
        while (tick !== 1'b1 && n < 8) begin
            if (rd_inc !== 1'b0 || tx !== 1'b1 || inc_count !== c0) bad = 1'b1;
            step();
            n++;
        end
        checks++; if (bad) begin errors++; $display("FAIL fetch early: read or start before tick, required none"); end
        checks++;
        if (rd_inc !== 1'b1) begin errors++; $display("FAIL fetch strobe: rd_inc=%b on tick, required 1", rd_inc); end
        step();
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1 || inc_count !== c0 + 1) begin
            errors++;
            $display("FAIL fetch latency: tx=%b busy=%b reads=%0d, required tx=0 busy=1 reads=1",
                     tx, busy, inc_count - c0);
        end
        wait_idle("fetch");
    endtask

    task automatic test_reset_mid();
        logic [31:0] bits;
        logic        bok;
        logic        bad_inc = 1'b0;
        int          c0 = inc_count;
        push(8'h3C);
        push(8'h5A);
        wait_fall("rst_mid");
        repeat (16) step();
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid bit3: tx=%b, required 1", tx); end
        rst = 1'b1;
        step();
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid abort: tx=%b busy=%b, required tx=1 busy=0", tx, busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (rd_inc !== 1'b0) bad_inc = 1'b1;
            step();
        end
        checks++; if (bad_inc) begin errors++; $display("FAIL rst_mid rd_inc: got 1 in reset, required 0"); end
        rst = 1'b0;
        wait_fall("rst_mid next");
        capture(10, -1, bits, bok);
        checks++;
        if (bits[9:0] !== 10'b1010110100) begin
            errors++; $display("FAIL rst_mid next frame: got %b, required %b", bits[9:0], 10'b1010110100);
        end
        wait_idle("rst_mid");
        checks++;
        if (inc_count !== c0 + 2) begin
            errors++; $display("FAIL rst_mid reads: got %0d, required 2", inc_count - c0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_par_toggle();
        test_empty();
        test_fetch_timing();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule
